// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, memory write and status signals of the instruction memory loader
//
// Signals:
//   Start      begin a load (honoured only in IDLE, DONE, ERROR)
//   ByteIn     stream byte
//   ByteValid  ByteIn is valid
//   ByteReady  loader accepts a byte this cycle
//   WrEn       one-cycle instruction memory write strobe
//   WrAddr     word address of the write
//   WrData     big-endian assembled instruction word
//   CpuHold    processor must stall while high
//   Done       level, load completed with matching checksum
//   Error      level, load aborted (bad count or checksum)
// Modports:
//   master  system controller / stream source side
//   slave   loader side
interface imem_loader_if #(
    parameter int ADDR_W = 4
);
    logic              Start;
    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [31:0]       WrData;
    logic              CpuHold;
    logic              Done;
    logic              Error;

    modport master (
        output Start, ByteIn, ByteValid,
        input  ByteReady, WrEn, WrAddr, WrData, CpuHold, Done, Error
    );

    modport slave (
        input  Start, ByteIn, ByteValid,
        output ByteReady, WrEn, WrAddr, WrData, CpuHold, Done, Error
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial loader assembling big-endian words into instruction memory with XOR checksum
//
// Parameters:
//   DEPTH   instruction memory depth in words (maximum program length)
//   ADDR_W  width of WrAddr, 2^ADDR_W >= DEPTH
// Ports:
//   Clk     rising-edge clock
//   Rst_n   asynchronous active-low reset
//   bus     imem_loader_if slave: byte stream in, memory write and status out
// Stream: count byte N, 4*N data bytes MSB first, checksum byte = XOR of data bytes.
module imem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    imem_loader_if.slave  bus
);

    // One extra bit so the word counter can hold N == DEPTH == 2^ADDR_W.
    localparam int        CW      = ADDR_W + 1;
    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        st;
    state_t        nxt;
    logic [CW-1:0] nwords;
    logic [CW-1:0] widx;
    logic [CW-1:0] widx_inc;
    logic [1:0]    bidx;
    logic [31:0]   word;
    logic [7:0]    csum;
    logic          rdy;
    logic          xfer;
    logic          count_bad;

    assign rdy       = (st == S_COUNT) || (st == S_DATA) || (st == S_CHECK);
    assign xfer      = bus.ByteValid && rdy;
    assign widx_inc  = widx + CW'(1);
    assign count_bad = (bus.ByteIn == 8'd0) || ({1'b0, bus.ByteIn} > DEPTH_B);

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            st <= S_IDLE;
        end else begin
            st <= nxt;
        end
    end

    // Next-state logic
    always_comb begin
        nxt = st;
        case (st)
            S_IDLE: begin
                if (bus.Start) nxt = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) nxt = count_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (xfer && (bidx == 2'd3)) nxt = S_WRITE;
            end
            S_WRITE: begin
                // widx still holds the index of the word being written here.
                nxt = (widx_inc == nwords) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (xfer) nxt = (bus.ByteIn == csum) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (bus.Start) nxt = S_COUNT;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Output decode; WrAddr/WrData come straight from registers so they are
    // stable for the whole WRITE cycle.
    always_comb begin
        bus.ByteReady = rdy;
        bus.WrEn      = (st == S_WRITE);
        bus.CpuHold   = rdy || (st == S_WRITE);
        bus.Done      = (st == S_DONE);
        bus.Error     = (st == S_ERROR);
        bus.WrAddr    = widx[ADDR_W-1:0];
        bus.WrData    = word;
    end

    // Datapath: word assembly, byte/word indices and checksum accumulator
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            nwords <= '0;
            widx   <= '0;
            bidx   <= '0;
            word   <= '0;
            csum   <= '0;
        end else begin
            case (st)
                S_COUNT: begin
                    if (xfer) begin
                        nwords <= CW'(bus.ByteIn);
                        widx   <= '0;
                        bidx   <= '0;
                        csum   <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word <= {word[23:0], bus.ByteIn};
                        csum <= csum ^ bus.ByteIn;
                        bidx <= bidx + 2'd1;
                    end
                end
                S_WRITE: begin
                    widx <= widx_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a stream-level reference model
module tb_imem_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wr_seen  = 0;
    int start_edge = 0;

    logic [7:0]  stream[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    logic        prev_wr = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: interpret the stream by its format rules.
    function automatic void model();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        n = int'(stream[0]);
        x = 8'h00;
        if (n == 0 || n > DEPTH) begin
            exp_done = 1'b0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                w = w * 256 + 32'(stream[1 + 4*k + b]);
                x = x ^ stream[1 + 4*k + b];
            end
            exp_addr.push_back(k);
            exp_data.push_back(w);
        end
        exp_done = (stream[4*n + 1] == x);
    endfunction

    task automatic build(input int n, input bit bad);
        logic [7:0] b;
        logic [7:0] x;
        stream.delete();
        stream.push_back(8'(n));
        x = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom_range(0, 255));
            stream.push_back(b);
            x = x ^ b;
        end
        stream.push_back(bad ? ~x : x);
    endtask

    // Per-cycle compare against the model's write list and state rules.
    always @(negedge Clk) begin
        if (Rst_n) begin
            check("cpuhold_rule", {31'b0, bus.CpuHold}, {31'b0, bus.ByteReady | bus.WrEn});
            check("done_error_excl", {31'b0, bus.Done & bus.Error}, 32'd0);
            if (bus.WrEn) begin
                wr_seen++;
                check("ready_in_write", {31'b0, bus.ByteReady}, 32'd0);
                check("wren_single", {31'b0, prev_wr}, 32'd0);
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    check("wr_addr", 32'(bus.WrAddr), 32'(exp_addr.pop_front()));
                    check("wr_data", bus.WrData, exp_data.pop_front());
                end
            end
            prev_wr = bus.WrEn;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        bus.ByteValid = 1'b0;
        repeat (gap) @(negedge Clk);
        bus.ByteValid = 1'b1;
        bus.ByteIn    = b;
        tries = 0;
        while (!bus.ByteReady && tries < 200) begin
            @(negedge Clk);
            tries++;
        end
        if (tries >= 200) check("ready_timeout", 32'd1, 32'd0);
        @(negedge Clk);
        bus.ByteValid = 1'b0;
    endtask

    task automatic do_start();
        bus.Start  = 1'b1;
        start_edge = cyc + 1;
        @(negedge Clk);
        bus.Start  = 1'b0;
    endtask

    task automatic run_load(input string tag, input int gapmax, input bit mid_start);
        int g;
        do_start();
        check({tag, "_ready_after_start"}, {31'b0, bus.ByteReady}, 32'd1);
        check({tag, "_hold_after_start"}, {31'b0, bus.CpuHold}, 32'd1);
        check({tag, "_status_cleared"}, {30'b0, bus.Done, bus.Error}, 32'd0);
        for (int i = 0; i < stream.size(); i++) begin
            g = (gapmax > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, gapmax) : 0;
            send_byte(stream[i], g);
            if (mid_start && i == 3) begin
                bus.Start = 1'b1;
                @(negedge Clk);
                bus.Start = 1'b0;
                check({tag, "_start_ignored"}, {31'b0, bus.CpuHold}, 32'd1);
            end
        end
        check({tag, "_done"}, {31'b0, bus.Done}, {31'b0, exp_done});
        check({tag, "_error"}, {31'b0, bus.Error}, {31'b0, !exp_done});
        check({tag, "_hold_low"}, {31'b0, bus.CpuHold}, 32'd0);
        check({tag, "_ready_low"}, {31'b0, bus.ByteReady}, 32'd0);
        check({tag, "_all_writes"}, 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        int w0;
        bus.Start = 1'b0;
        bus.ByteIn = 8'h00;
        bus.ByteValid = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", {bus.ByteReady, bus.WrEn, bus.WrAddr, bus.CpuHold, bus.Done, bus.Error},
              32'd0);
        check("reset_wrdata", bus.WrData, 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("idle_outputs", {bus.ByteReady, bus.WrEn, bus.CpuHold, bus.Done, bus.Error}, 32'd0);

        // Directed load with known words and checksum.
        stream = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44};
        model();
        check("model_w0", exp_data[0], 32'h11223344);
        check("model_w1", exp_data[1], 32'hA5A5A5A5);
        check("model_ok", {31'b0, exp_done}, 32'd1);
        run_load("t1", 0, 1'b0);
        check("t1_latency", 32'(cyc - start_edge), 32'd12);

        // Same image, bad checksum: writes still happen, then Error.
        stream[9] = 8'h45;
        model();
        check("model_bad", {31'b0, exp_done}, 32'd0);
        w0 = wr_seen;
        run_load("t2", 0, 1'b0);
        check("t2_writes", 32'(wr_seen - w0), 32'd2);

        // Good random load, then restart from DONE with a Start pulse mid-DATA.
        build(1, 1'b0);
        model();
        run_load("t3", 0, 1'b0);
        build(3, 1'b0);
        model();
        run_load("t4", 2, 1'b1);

        // Bad counts: no writes, Error right after the count byte.
        stream = '{8'h00};
        model();
        w0 = wr_seen;
        run_load("cnt0", 0, 1'b0);
        stream = '{8'(DEPTH + 1)};
        model();
        run_load("cnt17", 0, 1'b0);
        check("badcnt_no_writes", 32'(wr_seen - w0), 32'd0);

        // Full-depth load with random ByteValid gaps.
        build(DEPTH, 1'b0);
        model();
        w0 = wr_seen;
        run_load("full", 3, 1'b0);
        check("full_writes", 32'(wr_seen - w0), 32'(DEPTH));

        // Random lengths, occasionally corrupted checksum.
        for (int r = 0; r < 6; r++) begin
            build($urandom_range(1, DEPTH), ($urandom_range(0, 3) == 0));
            model();
            run_load("rand", 2, 1'b0);
        end

        // Reset after 6 data bytes of a 2-word load.
        build(2, 1'b0);
        model();
        do_start();
        for (int i = 0; i < 7; i++) send_byte(stream[i], 0);
        Rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {bus.ByteReady, bus.WrEn, bus.WrAddr, bus.CpuHold, bus.Done, bus.Error}, 32'd0);
        check("async_reset_wrdata", bus.WrData, 32'd0);
        check("first_word_written", 32'(exp_addr.size()), 32'd1);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("post_reset_idle", {bus.ByteReady, bus.WrEn, bus.CpuHold, bus.Done, bus.Error}, 32'd0);
        build(1, 1'b0);
        model();
        run_load("after_rst", 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial program loader that writes into the processor's word-addressed instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words, issuing one write per word at consecutive addresses starting at 0. A trailing XOR checksum validates the image. The processor is held off (`CpuHold`) for the whole load, so instruction fetch never observes a partially written program.

## Interface
Parameters:
- `DEPTH`, 16: instruction memory depth in words; maximum program length.
- `ADDR_W`, 4: width of `WrAddr`; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- `Clk`  in  1: single clock; all logic rising-edge.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `Start`  in  1: begin a load. Sampled only in IDLE, DONE or ERROR.
- `ByteIn`  in  8: stream byte.
- `ByteValid`  in  1: `ByteIn` is valid.
- `ByteReady`  out  1: loader accepts a byte this cycle.
- `WrEn`  out  1: one-cycle memory write strobe.
- `WrAddr`  out  ADDR_W: word address of the write.
- `WrData`  out  32: instruction word to write.
- `CpuHold`  out  1: processor must stall/reset while high.
- `Done`  out  1: level; load completed and checksum matched.
- `Error`  out  1: level; load aborted (bad count or checksum).

## Operation
- A byte transfer occurs on any rising edge where `ByteValid && ByteReady`.
- Stream format: 1 count byte N, then 4*N data bytes (MSB first per word), then 1 checksum byte. The checksum equals the XOR of all 4*N data bytes. The count byte is excluded from the checksum.
- States:
  - IDLE: `Start` -> COUNT.
  - COUNT: accept count byte. N==0 or N>DEPTH -> ERROR. Otherwise latch N, clear word index, byte index and checksum accumulator -> DATA.
  - DATA: accept bytes, shifting into the word register (`{word[23:0],ByteIn}`) and XORing into the accumulator. On the 4th byte of a word -> WRITE.
  - WRITE: one cycle; `WrEn`=1, `WrAddr`=word index, `WrData`=assembled word; `ByteReady`=0. Increment word index. If words written == N -> CHECK, else -> DATA.
  - CHECK: accept one byte. Equal to accumulator -> DONE, else -> ERROR.
  - DONE / ERROR: hold. `Start` -> COUNT, which clears `Done`/`Error`.
- `ByteReady`=1 exactly in COUNT, DATA and CHECK.
- `CpuHold`=1 in COUNT, DATA, WRITE and CHECK.
- `Start` is ignored in COUNT, DATA, WRITE and CHECK.
- Words written before an ERROR stay in memory; there is no rollback. `Error` with `CpuHold`=0 leaves the system controller to decide on a reload.
- Reset mid-load: immediately returns to IDLE with all outputs 0. The memory is not touched and no partial word is written.
- The word index never wraps, since N<=DEPTH is guaranteed by the COUNT check.

## Timing
- Reset values: `ByteReady`=0, `WrEn`=0, `WrAddr`=0, `WrData`=0, `CpuHold`=0, `Done`=0, `Error`=0. State = IDLE.
- `Start` high at edge k: COUNT from k+1, so `ByteReady` and `CpuHold` are high in cycle k+1.
- `WrEn` is high for exactly the cycle after the 4th byte handshake of each word. `WrAddr` and `WrData` are registered and stable while `WrEn`=1.
- With `ByteValid` held high, one word costs 5 cycles (4 transfers plus 1 WRITE). A full load takes 1 + 5N + 1 cycles after `Start`.
- `Done` or `Error` rises and `CpuHold` falls on the edge after the checksum byte transfer. For a bad count, this happens on the edge after the count byte transfer.
- Gaps in `ByteValid` stall the FSM with no state change and no lost bytes.

## Test plan
- Load N=2, bytes 11 22 33 44 A5 A5 A5 A5, checksum 44:
  - Writes (0, 0x11223344) and (1, 0xA5A5A5A5), each with a single-cycle `WrEn`.
  - `Done`=1 and `CpuHold`=0 exactly 12 cycles after `Start`.
- Same stream with checksum 45: both writes still occur, then `Error`=1, `Done`=0.
- Count byte 00 or DEPTH+1: no `WrEn` ever asserted; `Error`=1 on the next edge; `ByteReady` drops.
- Random `ByteValid` gaps during an N=DEPTH load:
  - Exactly DEPTH writes at addresses 0..DEPTH-1 with correct data.
  - `ByteReady`=0 in every WRITE cycle.
- Assert `Rst_n` low after 6 data bytes:
  - All outputs 0 asynchronously; no write for the partial second word.
  - After release, a fresh `Start` and full N=1 load succeed.
- `Start` pulsed in the middle of DATA is ignored. `Start` in DONE clears `Done` and restarts the load from address 0.
